// File: rtl/key_push_collision_if.sv
// rtl/key_push_collision_if.sv - frame, collision and position signals of the key mover
// master drives frame/collision events; slave is the key mover itself.
interface key_push_collision_if;
  logic               startOfFrame;
  logic               collisionSaviorKey;
  logic [3:0]         saviorHitEdgeCode;
  logic               collisionKeyBoarder;
  logic [3:0]         boarderHitEdgeCode;
  logic [3:0]         stopSaviorSignal;
  logic [10:0]        INITIAL_X;
  logic [10:0]        INITIAL_Y;
  logic               startLevel2;
  logic               startLevel3;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic [3:0]         stopKeySignal;
  logic               keyMoving;

  modport master (
    output startOfFrame, collisionSaviorKey, saviorHitEdgeCode,
    output collisionKeyBoarder, boarderHitEdgeCode, stopSaviorSignal,
    output INITIAL_X, INITIAL_Y, startLevel2, startLevel3,
    input  topLeftX, topLeftY, stopKeySignal, keyMoving
  );

  modport slave (
    input  startOfFrame, collisionSaviorKey, saviorHitEdgeCode,
    input  collisionKeyBoarder, boarderHitEdgeCode, stopSaviorSignal,
    input  INITIAL_X, INITIAL_Y, startLevel2, startLevel3,
    output topLeftX, topLeftY, stopKeySignal, keyMoving
  );
endinterface

// File: rtl/key_push_collision.sv
// rtl/key_push_collision.sv - pushable key mover with per-face push refusal
// Faces and edges are indexed {Left,Top,Right,Bottom} = bits {3,2,1,0}.
module key_push_collision #(
  parameter int KEY_SPEED      = 120,
  parameter int FACTOR         = 160,
  parameter int RELEASE_FRAMES = 2
) (
  input logic                clk,
  input logic                resetN,
  key_push_collision_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PUSH    = 2'd1;
  localparam logic [1:0] BLOCKED = 2'd2;

  localparam logic signed [31:0] STEP    = 32'(KEY_SPEED);
  localparam logic signed [31:0] BACK    = 32'(FACTOR);
  localparam logic [7:0]         REL_MAX = 8'(RELEASE_FRAMES);

  logic [1:0]         state, state_n;
  logic [1:0]         dir, dir_n, step_face, sel_face;
  logic [7:0]         rel_cnt, rel_n, rel_inc;
  logic [3:0]         pending, pending_n, wall, wall_n, hits, wall_set, wall_clr;
  logic [3:0]         block_vec, eff_pend, stop_q;
  logic               sel_valid, sel_ok, do_step, do_back;
  logic signed [31:0] fixed_x, fixed_y, dx, dy, init_fx, init_fy;

  assign init_fx = {15'd0, bus.INITIAL_X, 6'd0};
  assign init_fy = {15'd0, bus.INITIAL_Y, 6'd0};

  // A push on face i is refused when the wall on the edge it moves toward is set.
  assign block_vec = {wall[1], wall[0], wall[3], wall[2]};
  assign hits      = bus.collisionSaviorKey ? bus.saviorHitEdgeCode : 4'd0;
  assign wall_set  = bus.collisionKeyBoarder ? bus.boarderHitEdgeCode : 4'd0;
  assign eff_pend  = (bus.stopSaviorSignal != 4'd0) ? 4'd0 : pending;
  assign sel_valid = |eff_pend;
  assign sel_ok    = sel_valid && !block_vec[sel_face];
  assign rel_inc   = rel_cnt + 8'd1;

  // New hits in the frame-start cycle survive the clear for the next frame.
  assign pending_n = bus.startOfFrame ? hits : (pending | hits);

  always_comb begin
    sel_face = 2'd0;
    if (eff_pend[3])      sel_face = 2'd3;
    else if (eff_pend[1]) sel_face = 2'd1;
    else if (eff_pend[2]) sel_face = 2'd2;
  end

  always_comb begin
    state_n   = state;
    dir_n     = dir;
    rel_n     = rel_cnt;
    do_step   = 1'b0;
    do_back   = 1'b0;
    step_face = dir;
    if (bus.startOfFrame) begin
      case (state)
        IDLE: begin
          if (sel_ok) begin
            state_n   = PUSH;
            dir_n     = sel_face;
            step_face = sel_face;
            do_step   = 1'b1;
            rel_n     = 8'd0;
          end
        end
        PUSH: begin
          if (block_vec[dir]) begin
            do_back = 1'b1;
            state_n = BLOCKED;
            rel_n   = 8'd0;
          end else if (eff_pend[dir]) begin
            do_step = 1'b1;
            rel_n   = 8'd0;
          end else if (sel_ok) begin
            dir_n     = sel_face;
            step_face = sel_face;
            do_step   = 1'b1;
            rel_n     = 8'd0;
          end else if (rel_inc >= REL_MAX) begin
            state_n = IDLE;
            rel_n   = 8'd0;
          end else begin
            rel_n = rel_inc;
          end
        end
        BLOCKED: begin
          if (sel_ok && sel_face != dir) begin
            state_n   = PUSH;
            dir_n     = sel_face;
            step_face = sel_face;
            do_step   = 1'b1;
            rel_n     = 8'd0;
          end else if (sel_valid) begin
            rel_n = 8'd0;
          end else if (rel_inc >= REL_MAX) begin
            state_n = IDLE;
            rel_n   = 8'd0;
          end else begin
            rel_n = rel_inc;
          end
        end
        default: begin
          state_n = IDLE;
          rel_n   = 8'd0;
        end
      endcase
    end
  end

  // Pushing face i moves away from edge i, so a step on face i frees wall[i].
  always_comb begin
    dx = 32'sd0;
    dy = 32'sd0;
    if (do_step) begin
      case (step_face)
        2'd3:    dx = STEP;
        2'd1:    dx = -STEP;
        2'd2:    dy = STEP;
        default: dy = -STEP;
      endcase
    end else if (do_back) begin
      case (dir)
        2'd3:    dx = -BACK;
        2'd1:    dx = BACK;
        2'd2:    dy = -BACK;
        default: dy = BACK;
      endcase
    end
  end

  assign wall_clr = do_step ? (4'b0001 << step_face) : 4'd0;
  assign wall_n   = (wall & ~wall_clr) | wall_set;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      dir     <= 2'd3;
      rel_cnt <= 8'd0;
      pending <= 4'd0;
      wall    <= 4'd0;
      stop_q  <= 4'd0;
      fixed_x <= init_fx;
      fixed_y <= init_fy;
    end else if (bus.startLevel2 || bus.startLevel3) begin
      state   <= IDLE;
      dir     <= 2'd3;
      rel_cnt <= 8'd0;
      pending <= 4'd0;
      wall    <= 4'd0;
      stop_q  <= 4'd0;
      fixed_x <= init_fx;
      fixed_y <= init_fy;
    end else begin
      state   <= state_n;
      dir     <= dir_n;
      rel_cnt <= rel_n;
      pending <= pending_n;
      wall    <= wall_n;
      stop_q  <= block_vec;
      fixed_x <= fixed_x + dx;
      fixed_y <= fixed_y + dy;
    end
  end

  assign bus.topLeftX      = 11'(fixed_x / 32'sd64);
  assign bus.topLeftY      = 11'(fixed_y / 32'sd64);
  assign bus.stopKeySignal = stop_q;
  assign bus.keyMoving     = (state == PUSH);

endmodule

// File: tb/tb_key_push_collision.sv
// tb/tb_key_push_collision.sv - scoreboard bench for the key push mover
// Stimulus queues expected outputs; the monitor pops and compares on negedges.
module tb_key_push_collision;

  typedef struct {
    int x;
    int y;
    int stop;
    int mov;
  } exp_t;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  key_push_collision_if bus();

  key_push_collision #(
    .KEY_SPEED(120),
    .FACTOR(160),
    .RELEASE_FRAMES(2)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
  );

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  int    fx, fy;

  task automatic cmp(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t  e;
    string nm;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      cmp({nm, ".topLeftX"}, int'(bus.topLeftX), e.x);
      cmp({nm, ".topLeftY"}, int'(bus.topLeftY), e.y);
      cmp({nm, ".stopKeySignal"}, int'(bus.stopKeySignal), e.stop);
      cmp({nm, ".keyMoving"}, int'(bus.keyMoving), e.mov);
    end
  end

  task automatic expect_out(input string nm, input int ex, input int ey,
                            input int st, input int mv);
    exp_t e;
    #1;
    e.x    = ex / 64;
    e.y    = ey / 64;
    e.stop = st;
    e.mov  = mv;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Contact cycles first, then a clean frame-start pulse.
  task automatic do_frame(input logic [3:0] sav, input logic [3:0] brd,
                          input logic [3:0] ss);
    @(negedge clk);
    bus.collisionSaviorKey  = (sav != 4'd0);
    bus.saviorHitEdgeCode   = sav;
    bus.collisionKeyBoarder = (brd != 4'd0);
    bus.boarderHitEdgeCode  = brd;
    repeat (3) @(negedge clk);
    bus.collisionSaviorKey  = 1'b0;
    bus.saviorHitEdgeCode   = 4'd0;
    bus.collisionKeyBoarder = 1'b0;
    bus.boarderHitEdgeCode  = 4'd0;
    bus.stopSaviorSignal    = ss;
    bus.startOfFrame        = 1'b1;
    @(negedge clk);
    bus.startOfFrame        = 1'b0;
    bus.stopSaviorSignal    = 4'd0;
  endtask

  initial begin
    int n;
    bus.startOfFrame        = 1'b0;
    bus.collisionSaviorKey  = 1'b0;
    bus.saviorHitEdgeCode   = 4'd0;
    bus.collisionKeyBoarder = 1'b0;
    bus.boarderHitEdgeCode  = 4'd0;
    bus.stopSaviorSignal    = 4'd0;
    bus.INITIAL_X           = 11'd200;
    bus.INITIAL_Y           = 11'd100;
    bus.startLevel2         = 1'b0;
    bus.startLevel3         = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    fx = 12800;
    fy = 6400;
    expect_out("reset", fx, fy, 0, 0);

    for (int k = 1; k <= 8; k++) begin
      do_frame(4'b1000, 4'd0, 4'd0);
      fx += 120;
      expect_out($sformatf("left_push%0d", k), fx, fy, 0, 1);
    end

    do_frame(4'd0, 4'd0, 4'd0);
    expect_out("release1", fx, fy, 0, 1);
    do_frame(4'd0, 4'd0, 4'd0);
    expect_out("release2", fx, fy, 0, 0);

    do_frame(4'b1000, 4'd0, 4'd0);
    fx += 120;
    expect_out("approach", fx, fy, 0, 1);
    do_frame(4'b1000, 4'b0010, 4'd0);
    fx -= 160;
    expect_out("backoff", fx, fy, 8, 0);
    do_frame(4'b1000, 4'd0, 4'd0);
    expect_out("blocked_hold", fx, fy, 8, 0);
    do_frame(4'b0010, 4'd0, 4'd0);
    fx -= 120;
    expect_out("unblock", fx, fy, 0, 1);

    do_frame(4'd0, 4'd0, 4'd0);
    do_frame(4'd0, 4'd0, 4'd0);
    expect_out("idle_again", fx, fy, 0, 0);

    do_frame(4'b1000, 4'd0, 4'b0100);
    expect_out("savior_stopped", fx, fy, 0, 0);

    do_frame(4'b0100, 4'd0, 4'd0);
    fy += 120;
    expect_out("top_push", fx, fy, 0, 1);
    do_frame(4'b0001, 4'd0, 4'd0);
    fy -= 120;
    expect_out("bottom_relatch", fx, fy, 0, 1);

    @(negedge clk);
    bus.startLevel2 = 1'b1;
    @(negedge clk);
    bus.startLevel2 = 1'b0;
    fx = 12800;
    fy = 6400;
    expect_out("level2_reload", fx, fy, 0, 0);

    do_frame(4'b1010, 4'd0, 4'd0);
    fx += 120;
    expect_out("priority_left", fx, fy, 0, 1);

    @(negedge clk);
    #2 resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    fx = 12800;
    expect_out("async_reset", fx, fy, 0, 0);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
